// File: rtl/cpu_program_loader.sv
// cpu_program_loader: turns a UART command stream (START/ADDR/DATA/END) into iRAM word writes and gates the CPU.
// Latency: a completed DATA frame raises iRAM_write_enable on the next cycle; status registers update one cycle after the last byte.
// Backpressure: packet_ack is withheld while a write or PC reset is outstanding; each write is held until data_ack.
// Ports: clk/rst; byte input (packet_ready, uart_packet, packet_ack); iRAM write (iRAM_write_enable, extern_iRAM_addr,
//        iRAM_data_in, data_ack); CPU control (HALT_flag, PC_addr, cpu_paused, reset_PC);
//        status (load_busy, load_error, error_code, words_written).
module cpu_program_loader #(
    parameter int                DATA_W         = 24,
    parameter int                ADDR_W         = 8,
    parameter logic [ADDR_W-1:0] START_ADDR     = '0,
    parameter int                TIMEOUT_CYCLES = 1000000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              HALT_flag,
    input  logic              packet_ready,
    input  logic [7:0]        uart_packet,
    output logic              packet_ack,
    input  logic              data_ack,
    input  logic [ADDR_W-1:0] PC_addr,
    output logic              cpu_paused,
    output logic              reset_PC,
    output logic              iRAM_write_enable,
    output logic [ADDR_W-1:0] extern_iRAM_addr,
    output logic [DATA_W-1:0] iRAM_data_in,
    output logic              load_busy,
    output logic              load_error,
    output logic [2:0]        error_code,
    output logic [ADDR_W:0]   words_written
);
    localparam int BPW = (DATA_W + 7) / 8;
    localparam int ABW = (ADDR_W + 7) / 8;
    localparam int PB  = (BPW > ABW) ? BPW : ABW;
    localparam int IW  = (PB > 1) ? $clog2(PB) : 1;
    localparam int TW  = $clog2(TIMEOUT_CYCLES);

    localparam logic [7:0] C_START = 8'h01;
    localparam logic [7:0] C_ADDR  = 8'h02;
    localparam logic [7:0] C_DATA  = 8'h03;
    localparam logic [7:0] C_ENDR  = 8'h04;
    localparam logic [7:0] C_ENDK  = 8'h05;

    localparam logic [2:0] E_CMD  = 3'd1;
    localparam logic [2:0] E_ARM  = 3'd2;
    localparam logic [2:0] E_CHK  = 3'd3;
    localparam logic [2:0] E_TMO  = 3'd4;

    localparam logic [ADDR_W:0] WMAX = {1'b1, {ADDR_W{1'b0}}};

    typedef enum logic [1:0] {S_IDLE, S_PAYLOAD, S_WRITE, S_PC_WAIT} state_t;

    state_t            state_q, state_d;
    logic              ack_q, ack_d;
    logic [7:0]        cmd_q, cmd_d;
    logic [IW-1:0]     idx_q, idx_d;
    logic [PB*8-1:0]   buf_q, buf_d;
    logic [TW-1:0]     tmo_q, tmo_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [7:0]        chk_q, chk_d;
    logic              busy_q, busy_d;
    logic              paused_q, paused_d;
    logic              err_q, err_d;
    logic [2:0]        code_q, code_d;
    logic [ADDR_W:0]   words_q, words_d;

    logic              accept;
    logic [PB*8-1:0]   frame_val;   // payload including the byte accepted this cycle
    logic [7:0]        data_xor;
    int                need;

    always_comb begin
        state_d  = state_q;
        ack_d    = ack_q;
        cmd_d    = cmd_q;
        idx_d    = idx_q;
        buf_d    = buf_q;
        tmo_d    = tmo_q;
        addr_d   = addr_q;
        data_d   = data_q;
        chk_d    = chk_q;
        busy_d   = busy_q;
        paused_d = paused_q;
        err_d    = err_q;
        code_d   = code_q;
        words_d  = words_q;

        // Only the parsing states consume bytes; a held-high ready yields one byte per ack cycle.
        accept = packet_ready && !ack_q && (state_q == S_IDLE || state_q == S_PAYLOAD);
        if (accept) begin
            ack_d = 1'b1;
        end else if (!packet_ready) begin
            ack_d = 1'b0;
        end

        frame_val = buf_q;
        frame_val[int'(idx_q)*8 +: 8] = uart_packet;

        data_xor = '0;
        for (int i = 0; i < BPW; i++) begin
            data_xor = data_xor ^ frame_val[i*8 +: 8];
        end

        case (cmd_q)
            C_ADDR:  need = ABW;
            C_DATA:  need = BPW;
            default: need = 1;
        endcase

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    case (uart_packet)
                        C_START: begin
                            if (HALT_flag) begin
                                paused_d = 1'b1;
                                busy_d   = 1'b1;
                                chk_d    = '0;
                                words_d  = '0;
                                err_d    = 1'b0;
                                code_d   = '0;
                                addr_d   = START_ADDR;
                            end else begin
                                err_d  = 1'b1;
                                code_d = E_ARM;
                            end
                        end
                        C_ADDR, C_DATA, C_ENDR, C_ENDK: begin
                            cmd_d   = uart_packet;
                            idx_d   = '0;
                            buf_d   = '0;
                            tmo_d   = '0;
                            state_d = S_PAYLOAD;
                        end
                        default: begin
                            err_d  = 1'b1;
                            code_d = E_CMD;
                        end
                    endcase
                end
            end
            S_PAYLOAD: begin
                if (accept) begin
                    tmo_d = '0;
                    buf_d = frame_val;
                    if (int'(idx_q) == need - 1) begin
                        state_d = S_IDLE;
                        if (!busy_q) begin
                            // Unarmed frames are drained completely, then flagged.
                            err_d  = 1'b1;
                            code_d = E_ARM;
                        end else if (cmd_q == C_ADDR) begin
                            addr_d = frame_val[ADDR_W-1:0];
                        end else if (cmd_q == C_DATA) begin
                            data_d  = frame_val[DATA_W-1:0];
                            chk_d   = chk_q ^ data_xor;
                            state_d = S_WRITE;
                        end else begin
                            busy_d = 1'b0;
                            if (frame_val[7:0] != chk_q) begin
                                // CPU stays paused; host restarts from START.
                                err_d  = 1'b1;
                                code_d = E_CHK;
                            end else if (cmd_q == C_ENDK) begin
                                paused_d = 1'b0;
                            end else begin
                                state_d = S_PC_WAIT;
                            end
                        end
                    end else begin
                        idx_d = idx_q + IW'(1);
                    end
                end else if (tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
                    // Frame abandoned; any partial word is dropped, session stays armed.
                    state_d = S_IDLE;
                    err_d   = 1'b1;
                    code_d  = E_TMO;
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
            end
            S_WRITE: begin
                if (data_ack) begin
                    addr_d  = addr_q + ADDR_W'(1);
                    words_d = (words_q == WMAX) ? words_q : words_q + (ADDR_W+1)'(1);
                    state_d = S_IDLE;
                end
            end
            S_PC_WAIT: begin
                if (PC_addr == '0) begin
                    paused_d = 1'b0;
                    state_d  = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            ack_q    <= 1'b0;
            cmd_q    <= '0;
            idx_q    <= '0;
            buf_q    <= '0;
            tmo_q    <= '0;
            addr_q   <= START_ADDR;
            data_q   <= '0;
            chk_q    <= '0;
            busy_q   <= 1'b0;
            paused_q <= 1'b0;
            err_q    <= 1'b0;
            code_q   <= '0;
            words_q  <= '0;
        end else begin
            state_q  <= state_d;
            ack_q    <= ack_d;
            cmd_q    <= cmd_d;
            idx_q    <= idx_d;
            buf_q    <= buf_d;
            tmo_q    <= tmo_d;
            addr_q   <= addr_d;
            data_q   <= data_d;
            chk_q    <= chk_d;
            busy_q   <= busy_d;
            paused_q <= paused_d;
            err_q    <= err_d;
            code_q   <= code_d;
            words_q  <= words_d;
        end
    end

    // Enable and PC reset decode straight from state so rst drops them asynchronously.
    assign iRAM_write_enable = (state_q == S_WRITE);
    assign reset_PC          = (state_q == S_PC_WAIT);
    assign packet_ack        = ack_q;
    assign cpu_paused        = paused_q;
    assign extern_iRAM_addr  = addr_q;
    assign iRAM_data_in      = data_q;
    assign load_busy         = busy_q;
    assign load_error        = err_q;
    assign error_code        = code_q;
    assign words_written     = words_q;
endmodule

// File: tb/tb_cpu_program_loader.sv
// tb_cpu_program_loader: frame-level reference model plus randomized command stream for cpu_program_loader.
// Latency: host and iRAM/PC responders run with random gaps; status compared after each frame settles.
// Backpressure: data_ack randomly delayed or stalled; PC_addr reaches zero after a random delay.
module tb_cpu_program_loader;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        HALT_flag = 1'b1;
    logic        packet_ready = 1'b0;
    logic [7:0]  uart_packet = 8'h00;
    logic        packet_ack;
    logic        data_ack = 1'b0;
    logic [7:0]  PC_addr = 8'h33;
    logic        cpu_paused, reset_PC, iRAM_write_enable;
    logic [7:0]  extern_iRAM_addr;
    logic [23:0] iRAM_data_in;
    logic        load_busy, load_error;
    logic [2:0]  error_code;
    logic [8:0]  words_written;

    always #5 clk = ~clk;

    cpu_program_loader #(.TIMEOUT_CYCLES(16)) dut (
        .clk(clk), .rst(rst), .HALT_flag(HALT_flag), .packet_ready(packet_ready),
        .uart_packet(uart_packet), .packet_ack(packet_ack), .data_ack(data_ack),
        .PC_addr(PC_addr), .cpu_paused(cpu_paused), .reset_PC(reset_PC),
        .iRAM_write_enable(iRAM_write_enable), .extern_iRAM_addr(extern_iRAM_addr),
        .iRAM_data_in(iRAM_data_in), .load_busy(load_busy), .load_error(load_error),
        .error_code(error_code), .words_written(words_written)
    );

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference model: session-level state derived from the command rules.
    bit          m_armed, m_paused, m_err;
    int          m_code, m_words;
    logic [7:0]  m_addr, m_chk;
    logic [31:0] expq[$];
    logic [31:0] wlog[$];
    logic [7:0]  frame[$];

    task automatic model_reset();
        m_armed = 0; m_paused = 0; m_err = 0; m_code = 0; m_words = 0;
        m_addr = 8'h00; m_chk = 8'h00;
    endtask

    task automatic model_apply();
        case (frame[0])
            8'h01: if (HALT_flag) begin
                m_armed = 1; m_paused = 1; m_chk = 0; m_words = 0;
                m_err = 0; m_code = 0; m_addr = 8'h00;
            end else begin
                m_err = 1; m_code = 2;
            end
            8'h02: if (m_armed) m_addr = frame[1];
                   else begin m_err = 1; m_code = 2; end
            8'h03: if (m_armed) begin
                expq.push_back({m_addr, frame[3], frame[2], frame[1]});
                m_addr = m_addr + 8'd1;
                if (m_words < 256) m_words++;
                m_chk = m_chk ^ frame[1] ^ frame[2] ^ frame[3];
            end else begin
                m_err = 1; m_code = 2;
            end
            8'h04, 8'h05: if (!m_armed) begin
                m_err = 1; m_code = 2;
            end else begin
                m_armed = 0;
                if (frame[1] == m_chk) m_paused = 0;
                else begin m_err = 1; m_code = 3; end
            end
            default: begin m_err = 1; m_code = 1; end
        endcase
    endtask

    // iRAM responder and per-cycle write/PC checker.
    bit          stall_ack = 0;
    bit          was_en = 0;
    logic [7:0]  h_addr;
    logic [23:0] h_data;
    logic        prev_rpc = 0;
    logic [7:0]  prev_pc = 8'h33;
    logic [31:0] e;

    initial forever begin
        @(negedge clk);
        if (rst) begin
            was_en = 0; data_ack = 0; prev_rpc = 0;
        end else begin
            if (iRAM_write_enable) begin
                if (was_en) begin
                    check("wr_addr_stable", extern_iRAM_addr, h_addr);
                    check("wr_data_stable", iRAM_data_in, h_data);
                end else begin
                    was_en = 1; h_addr = extern_iRAM_addr; h_data = iRAM_data_in;
                end
            end else begin
                was_en = 0;
            end
            if (prev_rpc && !reset_PC) begin
                check("pc_zero_at_release", prev_pc, 0);
                check("unpause_with_release", cpu_paused, 0);
            end
            if (reset_PC) check("paused_in_pc_wait", cpu_paused, 1);
            prev_rpc = reset_PC;
            prev_pc  = PC_addr;
            if (iRAM_write_enable) data_ack = !stall_ack && ($urandom_range(0, 2) == 0);
            else                   data_ack = ($urandom_range(0, 7) == 0);
            if (iRAM_write_enable && data_ack) begin
                if (expq.size() == 0) begin
                    check("unexpected_write", 1, 0);
                end else begin
                    e = expq.pop_front();
                    check("wr_addr", extern_iRAM_addr, e[31:24]);
                    check("wr_data", iRAM_data_in, e[23:0]);
                end
                wlog.push_back({extern_iRAM_addr, iRAM_data_in});
                was_en = 0;
            end
        end
    end

    // CPU responder: PC returns to zero a few cycles after reset_PC rises.
    int pc_cnt = 0;
    initial forever begin
        @(posedge clk);
        #2;
        if (reset_PC) begin
            if (pc_cnt == 0) PC_addr = 8'h00;
            else pc_cnt--;
        end else begin
            PC_addr = 8'h33;
            pc_cnt  = $urandom_range(0, 4);
        end
    end

    task automatic send_byte(input logic [7:0] b, input int gap);
        int n;
        n = 0;
        while (packet_ack && n < 300) begin @(negedge clk); n++; end
        if (packet_ack) check("ack_release_timeout", 1, 0);
        uart_packet  = b;
        packet_ready = 1'b1;
        n = 0;
        do begin @(negedge clk); n++; end while (!packet_ack && n < 300);
        if (!packet_ack) check("ack_timeout", 0, 1);
        packet_ready = 1'b0;
        repeat (gap) @(negedge clk);
    endtask

    task automatic send_bytes();
        model_apply();
        foreach (frame[i]) send_byte(frame[i], $urandom_range(0, 3));
    endtask

    task automatic finish_frame();
        int n;
        n = 0;
        do begin @(negedge clk); n++; end while ((iRAM_write_enable || reset_PC) && n < 300);
        repeat (2) @(negedge clk);
        check("settle_we", iRAM_write_enable, 0);
        check("settle_rpc", reset_PC, 0);
        check("load_busy", load_busy, m_armed);
        check("cpu_paused", cpu_paused, m_paused);
        check("load_error", load_error, m_err);
        check("error_code", error_code, m_code);
        check("words_written", words_written, m_words);
        check("addr", extern_iRAM_addr, m_addr);
    endtask

    task automatic send_frame();
        send_bytes();
        finish_frame();
    endtask

    int base, rises, r;
    logic pa;

    initial begin
        model_reset();
        #1;
        check("rst_ack", packet_ack, 0);
        check("rst_paused", cpu_paused, 0);
        check("rst_rpc", reset_PC, 0);
        check("rst_we", iRAM_write_enable, 0);
        check("rst_addr", extern_iRAM_addr, 0);
        check("rst_data", iRAM_data_in, 0);
        check("rst_busy", load_busy, 0);
        check("rst_err", load_error, 0);
        check("rst_code", error_code, 0);
        check("rst_words", words_written, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Reset asserted while a write is pending.
        frame = '{8'h01}; send_frame();
        stall_ack = 1;
        frame = '{8'h03, 8'h01, 8'h02, 8'h03}; send_bytes();
        @(negedge clk);
        check("t1_we_pending", iRAM_write_enable, 1);
        #2 rst = 1'b1;
        #1;
        check("t1_we_async", iRAM_write_enable, 0);
        check("t1_paused", cpu_paused, 0);
        check("t1_addr", extern_iRAM_addr, 0);
        check("t1_busy", load_busy, 0);
        check("t1_words", words_written, 0);
        expq.delete();
        model_reset();
        stall_ack = 0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Protocol errors from the unarmed state.
        frame = '{8'h7E}; send_frame();
        check("t5_badcmd", error_code, 1);
        HALT_flag = 0;
        frame = '{8'h01}; send_frame();
        check("t5_nohalt", error_code, 2);
        HALT_flag = 1;
        frame = '{8'h03, 8'h01, 8'h02, 8'h03}; send_frame();
        check("t5_unarmed", error_code, 2);

        // Basic load ending with END_KEEP.
        base = wlog.size();
        frame = '{8'h01}; send_frame();
        frame = '{8'h03, 8'h56, 8'h34, 8'h12}; send_frame();
        frame = '{8'h03, 8'hCC, 8'hBB, 8'hAA}; send_frame();
        check("t2_model_chk", m_chk, 8'hAD);
        frame = '{8'h05, 8'hAD}; send_frame();
        check("t2_w0", wlog[base], 32'h00123456);
        check("t2_w1", wlog[base+1], 32'h01AABBCC);
        check("t2_words", words_written, 2);
        check("t2_paused", cpu_paused, 0);

        // Explicit address with wrap, END_RESET through PC_WAIT.
        base = wlog.size();
        frame = '{8'h01}; send_frame();
        frame = '{8'h02, 8'hFF}; send_frame();
        frame = '{8'h03, 8'h01, 8'h00, 8'h00}; send_frame();
        frame = '{8'h03, 8'h01, 8'h00, 8'h00}; send_frame();
        frame = '{8'h04, 8'h00}; send_bytes();
        check("t3_rpc_high", reset_PC, 1);
        finish_frame();
        check("t3_w0", wlog[base], 32'hFF000001);
        check("t3_w1", wlog[base+1], 32'h00000001);
        check("t3_paused", cpu_paused, 0);

        // Checksum mismatch, then recovery by START.
        frame = '{8'h01}; send_frame();
        frame = '{8'h03, 8'h05, 8'h06, 8'h07}; send_frame();
        frame = '{8'h05, 8'h00}; send_frame();
        check("t4_code", error_code, 3);
        check("t4_err", load_error, 1);
        check("t4_paused", cpu_paused, 1);
        frame = '{8'h01}; send_frame();
        check("t4_cleared", error_code, 0);

        // Inter-byte timeout inside a DATA frame.
        send_byte(8'h03, 0);
        send_byte(8'h11, 0);
        repeat (10) @(negedge clk);
        check("t6_no_early_tmo", error_code, 0);
        repeat (14) @(negedge clk);
        check("t6_tmo_code", error_code, 4);
        m_err = 1; m_code = 4;
        finish_frame();

        // Held-high ready yields a single byte.
        frame = '{8'h03, 8'hAA, 8'hBB, 8'hCC};
        model_apply();
        send_byte(8'h03, 1);
        uart_packet = 8'hAA; packet_ready = 1'b1;
        rises = 0; pa = packet_ack;
        repeat (10) begin
            @(negedge clk);
            if (packet_ack && !pa) rises++;
            pa = packet_ack;
        end
        packet_ready = 1'b0;
        check("t6_one_accept", rises, 1);
        send_byte(8'hBB, 1);
        send_byte(8'hCC, 1);
        finish_frame();
        check("t6_word", wlog[wlog.size()-1][23:0], 24'hCCBBAA);

        // Write held through a long data_ack stall.
        stall_ack = 1;
        frame = '{8'h03, 8'h9A, 8'h78, 8'h56}; send_bytes();
        repeat (20) @(negedge clk);
        check("t6_we_held", iRAM_write_enable, 1);
        stall_ack = 0;
        finish_frame();

        // Randomized command stream.
        for (int k = 0; k < 60; k++) begin
            r = $urandom_range(0, 99);
            HALT_flag = 1;
            if (r < 10) begin
                HALT_flag = ($urandom_range(0, 4) != 0);
                frame = '{8'h01};
            end else if (r < 25) begin
                frame = '{8'h02, 8'($urandom_range(0, 255))};
            end else if (r < 70) begin
                frame = '{8'h03, 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
                          8'($urandom_range(0, 255))};
            end else if (r < 85) begin
                frame = '{(($urandom_range(0, 1) == 0) ? 8'h04 : 8'h05),
                          (($urandom_range(0, 3) == 0) ? (m_chk ^ 8'($urandom_range(1, 255))) : m_chk)};
            end else if (r < 90) begin
                frame = '{(($urandom_range(0, 1) == 0) ? 8'h7E : 8'hFF)};
            end else begin
                frame = '{8'h01};
            end
            send_frame();
        end

        check("expq_drained", expq.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        failures++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
